event_indicator: RTL and testbench

Parametrised multi-channel event pulse stretcher that turns short game-event triggers (goal scored, break-beam hits) into fixed-length indicator pulses for LEDs and an audio enable. It generalises the fixed two-channel, level-triggered LED hold logic to N channels with rising-edge detection, a selectable retrigger mode, per-channel saturating event counters and a synchronous clear. It sits in the top-level wrapper on the divided processor clock, between the register-file event flags and the LED / AudioController inputs.

---
 rtl/event_indicator.sv | 112 +++++++++++
 tb/tb_event_indicator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_indicator.sv
// Multi-channel event pulse stretcher: rising-edge triggers become fixed-length
// indicator pulses, with optional retrigger, saturating event counters and clear.
module event_indicator #(
    parameter int CHANNELS    = 2,
    parameter int HOLD_CYCLES = 50000000,
    parameter int RETRIGGER   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   trig,
    input  logic [CHANNELS-1:0]   enable,
    input  logic                  clear,
    output logic [CHANNELS-1:0]   led,
    output logic [CHANNELS-1:0]   start_pulse,
    output logic                  any_active,
    output logic [8*CHANNELS-1:0] event_count
);

    localparam int            CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [CW-1:0]       cnt_q   [CHANNELS];
    logic [CW-1:0]       cnt_d   [CHANNELS];
    logic [7:0]          count_q [CHANNELS];
    logic [7:0]          count_d [CHANNELS];
    logic [CHANNELS-1:0] trig_q;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] led_d;
    logic [CHANNELS-1:0] start_d;

    // clear outranks a coincident rise: it is neither counted nor started
    assign accept = trig & ~trig_q & enable & {CHANNELS{~clear}};

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            count_d[i] = count_q[i];
            start_d[i] = 1'b0;

            if (clear) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                count_d[i] = '0;
            end else begin
                if (accept[i] && count_q[i] != 8'hFF) begin
                    count_d[i] = count_q[i] + 8'd1;
                end
                case (state_q[i])
                    IDLE: begin
                        if (accept[i]) begin
                            state_d[i] = ACTIVE;
                            cnt_d[i]   = HOLD_LOAD;
                            start_d[i] = 1'b1;
                        end
                    end
                    ACTIVE: begin
                        // a retrigger wins even on the final (cnt == 0) cycle
                        if (accept[i] && RETRIGGER != 0) begin
                            cnt_d[i] = HOLD_LOAD;
                        end else if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
            led_d[i] = (state_d[i] == ACTIVE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the per-channel arrays are plain flops, not RAM, so resetting them is intended.
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                count_q[i] <= '0;
            end
            trig_q      <= '0;
            led         <= '0;
            start_pulse <= '0;
            any_active  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                count_q[i] <= count_d[i];
            end
            trig_q      <= trig;
            led         <= led_d;
            start_pulse <= start_d;
            any_active  <= |led_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign event_count[8*g +: 8] = count_q[g];
    end

endmodule

// File: tb/tb_event_indicator.sv
// Scoreboard bench for event_indicator: three instances cover hold=4 without and
// with retrigger, and a one-cycle hold; expectations are queued ahead and checked by a monitor.
module tb_event_indicator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  trig_a, en_a, led_a, st_a;
    logic        clr_a, any_a;
    logic [23:0] cnt_a;
    logic [2:0]  trig_b, en_b, led_b, st_b;
    logic        clr_b, any_b;
    logic [23:0] cnt_b;
    logic        trig_c, en_c, clr_c, led_c, st_c, any_c;
    logic [7:0]  cnt_c;

    event_indicator #(.CHANNELS(3), .HOLD_CYCLES(4), .RETRIGGER(0)) dut_a (
        .clk(clk), .reset(reset), .trig(trig_a), .enable(en_a), .clear(clr_a),
        .led(led_a), .start_pulse(st_a), .any_active(any_a), .event_count(cnt_a));

    event_indicator #(.CHANNELS(3), .HOLD_CYCLES(4), .RETRIGGER(1)) dut_b (
        .clk(clk), .reset(reset), .trig(trig_b), .enable(en_b), .clear(clr_b),
        .led(led_b), .start_pulse(st_b), .any_active(any_b), .event_count(cnt_b));

    event_indicator #(.CHANNELS(1), .HOLD_CYCLES(1), .RETRIGGER(1)) dut_c (
        .clk(clk), .reset(reset), .trig(trig_c), .enable(en_c), .clear(clr_c),
        .led(led_c), .start_pulse(st_c), .any_active(any_c), .event_count(cnt_c));

    typedef struct {
        int          cyc;
        int          dut;
        logic [2:0]  led;
        logic [2:0]  st;
        logic [23:0] cnt;
        bit          only_cnt;
        string       tag;
    } exp_t;

    exp_t  sb[$];
    int    cyc    = 0;
    int    base   = 0;
    int    checks = 0;
    int    errors = 0;
    string scen   = "reset";

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    task automatic push(input int d, input int ofs, input logic [2:0] l, input logic [2:0] s,
                        input logic [23:0] c, input bit only_cnt = 1'b0);
        exp_t e;
        e.cyc      = base + ofs;
        e.dut      = d;
        e.led      = l;
        e.st       = s;
        e.cnt      = c;
        e.only_cnt = only_cnt;
        e.tag      = $sformatf("%s_dut%0d", scen, d);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic mark();
        base = cyc;
    endtask

    // monitor: outputs are sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        exp_t        e;
        logic [2:0]  l, s;
        logic        a;
        logic [23:0] c;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin l = led_a; s = st_a; a = any_a; c = cnt_a; end
                1:       begin l = led_b; s = st_b; a = any_b; c = cnt_b; end
                default: begin l = {2'b00, led_c}; s = {2'b00, st_c}; a = any_c; c = {16'h0, cnt_c}; end
            endcase
            if (e.cyc != cyc) begin
                check({e.tag, "_missed"}, 24'(cyc), 24'(e.cyc));
            end else begin
                if (!e.only_cnt) begin
                    check({e.tag, "_led"}, 24'(l), 24'(e.led));
                    check({e.tag, "_start"}, 24'(s), 24'(e.st));
                    check({e.tag, "_any"}, 24'(a), 24'(|e.led));
                end
                check({e.tag, "_count"}, c, e.cnt);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        trig_a = '0; en_a = 3'b111; clr_a = 1'b0;
        trig_b = '0; en_b = 3'b111; clr_b = 1'b0;
        trig_c = 1'b0; en_c = 1'b1; clr_c = 1'b0;

        push(0, 1, 3'b000, 3'b000, 24'h0);
        push(0, 2, 3'b000, 3'b000, 24'h0);
        push(1, 2, 3'b000, 3'b000, 24'h0);
        push(2, 2, 3'b000, 3'b000, 24'h0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // single one-cycle trigger: four-cycle led, one-cycle start strobe
        scen = "single"; mark();
        push(0, 1, 3'b001, 3'b001, 24'h000001);
        for (int o = 2; o <= 4; o++) push(0, o, 3'b001, 3'b000, 24'h000001);
        push(0, 5, 3'b000, 3'b000, 24'h000001);
        trig_a = 3'b001; tick(); trig_a = '0;
        repeat (5) tick();

        // second rise two cycles into the hold: ignored by dut_a, restarts dut_b
        scen = "retrig"; mark();
        for (int o = 1; o <= 7; o++) begin
            if (o <= 5)
                push(0, o, (o <= 4) ? 3'b010 : 3'b000, (o == 1) ? 3'b010 : 3'b000,
                     (o < 3) ? 24'h000101 : 24'h000201);
            push(1, o, (o <= 6) ? 3'b010 : 3'b000, (o == 1) ? 3'b010 : 3'b000,
                 (o < 3) ? 24'h000100 : 24'h000200);
        end
        trig_a = 3'b010; trig_b = 3'b010; tick();
        trig_a = 3'b000; trig_b = 3'b000; tick();
        trig_a = 3'b010; trig_b = 3'b010; tick();
        trig_a = 3'b000; trig_b = 3'b000;
        repeat (5) tick();

        // trig held high for 20 cycles yields one pulse
        scen = "held"; mark();
        push(0, 1,  3'b100, 3'b100, 24'h010201);
        push(0, 4,  3'b100, 3'b000, 24'h010201);
        push(0, 5,  3'b000, 3'b000, 24'h010201);
        push(0, 20, 3'b000, 3'b000, 24'h010201);
        push(0, 22, 3'b000, 3'b000, 24'h010201);
        trig_a = 3'b100; repeat (20) tick();
        trig_a = 3'b000; repeat (3) tick();

        // disabled channel discards the rise entirely
        scen = "disabled"; mark();
        push(0, 1, 3'b000, 3'b000, 24'h010201);
        push(0, 2, 3'b000, 3'b000, 24'h010201);
        en_a = 3'b011; trig_a = 3'b100; tick(); tick();
        trig_a = 3'b000; tick();
        en_a = 3'b111; tick();

        // 300 accepted rises on channel 0 saturate its counter
        scen = "sat";
        for (int k = 0; k < 300; k++) begin
            if (k == 100) begin
                mark();
                push(0, 1, 3'b000, 3'b000, 24'h010266, 1'b1);
            end
            trig_a = 3'b001; tick();
            trig_a = 3'b000; tick();
        end
        mark();
        push(0, 1, 3'b000, 3'b000, 24'h0102FF, 1'b1);
        push(0, 6, 3'b000, 3'b000, 24'h0102FF);
        repeat (7) tick();

        // clear kills an active pulse and beats a coincident rise
        scen = "clear"; mark();
        push(0, 1, 3'b001, 3'b001, 24'h0102FF);
        push(0, 2, 3'b000, 3'b000, 24'h0);
        push(0, 3, 3'b000, 3'b000, 24'h0);
        push(0, 4, 3'b000, 3'b000, 24'h0);
        trig_a = 3'b001; tick();
        trig_a = 3'b010; clr_a = 1'b1; tick();
        clr_a = 1'b0; tick(); tick();
        trig_a = 3'b000; tick();

        // simultaneous rises, then asynchronous reset mid-pulse
        scen = "simul"; mark();
        push(0, 1, 3'b101, 3'b101, 24'h010001);
        push(0, 2, 3'b101, 3'b000, 24'h010001);
        push(0, 3, 3'b000, 3'b000, 24'h0);
        push(0, 4, 3'b000, 3'b000, 24'h0);
        push(0, 8, 3'b000, 3'b000, 24'h0);
        trig_a = 3'b101; tick();
        trig_a = 3'b000; tick();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (5) tick();

        // one-cycle hold
        scen = "hold1"; mark();
        push(2, 1, 3'b001, 3'b001, 24'h1);
        push(2, 2, 3'b000, 3'b000, 24'h1);
        trig_c = 1'b1; tick();
        trig_c = 1'b0; tick(); tick();

        // rise every other cycle: led follows 1,0,1,0
        scen = "alt"; mark();
        for (int o = 1; o <= 6; o++)
            push(2, o, (o % 2 == 1) ? 3'b001 : 3'b000, (o % 2 == 1) ? 3'b001 : 3'b000,
                 24'(1 + (o + 1) / 2));
        for (int k = 0; k < 3; k++) begin
            trig_c = 1'b1; tick();
            trig_c = 1'b0; tick();
        end
        tick();

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) check("drain_timeout", 24'(sb.size()), 24'h0);

        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
